// File: rtl/pipe_stage_skid_if.sv
// Handshake bundle between two pipeline stages: upstream payload in, downstream payload out,
// plus the hazard-unit freeze and squash controls that act on the stage.
interface pipe_stage_skid_if #(
  parameter int DATA_W = 64
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              flush;
  logic              freeze;

  modport master (
    output in_valid, in_data, out_ready, flush, freeze,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush, freeze,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a 2-entry skid buffer, freeze/flush control and
// saturating stall/flush counters; in_ready and out_valid come straight from flops.
module pipe_stage_skid #(
  parameter int                DATA_W    = 64,
  parameter logic [DATA_W-1:0] FLUSH_VAL = '0,
  parameter int                CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  pipe_stage_skid_if.slave bus,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // State encoding doubles as the occupancy count.
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]        state_reg, state_next;
  logic [DATA_W-1:0] main_reg, main_next;
  logic [DATA_W-1:0] skid_reg, skid_next;
  logic              out_valid_reg;
  logic              in_ready_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  flush_cnt_reg;
  logic              in_fire;
  logic              out_fire;

  assign in_fire  = bus.in_valid & in_ready_reg;
  assign out_fire = out_valid_reg & bus.out_ready & ~bus.freeze;

  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      ST_EMPTY: begin
        if (in_fire) begin
          state_next = ST_ONE;
          main_next  = bus.in_data;
        end
      end
      ST_ONE: begin
        if (in_fire && out_fire) begin
          main_next = bus.in_data;
        end else if (in_fire) begin
          state_next = ST_FULL;
          skid_next  = bus.in_data;
        end else if (out_fire) begin
          state_next = ST_EMPTY;
          main_next  = FLUSH_VAL;
        end
      end
      ST_FULL: begin
        if (out_fire) begin
          state_next = ST_ONE;
          main_next  = skid_reg;
        end
      end
      default: begin
        state_next = ST_EMPTY;
        main_next  = FLUSH_VAL;
      end
    endcase
    // Squash overrides everything; a same-cycle in_fire is accepted and dropped.
    if (bus.flush) begin
      state_next = ST_EMPTY;
      main_next  = FLUSH_VAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_EMPTY;
      main_reg      <= FLUSH_VAL;
      skid_reg      <= FLUSH_VAL;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b1;
      stall_cnt_reg <= '0;
      flush_cnt_reg <= '0;
    end else begin
      state_reg     <= state_next;
      main_reg      <= main_next;
      skid_reg      <= skid_next;
      out_valid_reg <= (state_next != ST_EMPTY);
      in_ready_reg  <= (state_next != ST_FULL);
      if (out_valid_reg && !out_fire && (stall_cnt_reg != '1))
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      if (bus.flush && (state_reg != ST_EMPTY) && (flush_cnt_reg != '1))
        flush_cnt_reg <= flush_cnt_reg + 1'b1;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.in_ready  = in_ready_reg;
  assign bus.out_data  = main_reg;
  assign occupancy     = state_reg;
  assign stall_cnt     = stall_cnt_reg;
  assign flush_cnt     = flush_cnt_reg;

endmodule
